// File: rtl/data_mem_arb_pkg.sv
// data_mem_arb_pkg: shared types and default sizes for the data memory arbiter
package data_mem_arb_pkg;
  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH = 256;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef struct packed {
    logic write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin select starting at rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);
  logic [IW-1:0] j;
  // Walk from the farthest candidate back to rr_ptr so the nearest valid requester wins
  always_comb begin
    grant_idx = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[j]) grant_idx = j;
    end
    grant = |req ? NUM_REQ'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of a single-port data memory; DATA_MEM_ARB_BOUNDS_CHECK_EN adds address bounds checking
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_read_en,
  output logic                          mem_write_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  input  logic [DATA_WIDTH-1:0]         mem_read_data
);
  localparam int IW = $clog2(NUM_REQ);
  if (ADDR_WIDTH != DEF_ADDR_WIDTH || DATA_WIDTH != DEF_DATA_WIDTH || MEM_DEPTH < 1) begin : g_cfg_check
    $error("data_mem_arbiter: widths must match mem_req_t and MEM_DEPTH must be positive");
  end
  arb_state_t state;
  mem_req_t lat;
  logic [IW-1:0] rr_ptr, gid, g_idx;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic accept, access, lat_err;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (.req(req_valid), .rr_ptr(rr_ptr), .grant(grant), .grant_idx(g_idx));
  assign sel_addr = ADDR_WIDTH'(req_addr >> (g_idx * ADDR_WIDTH));
  assign sel_wdata = DATA_WIDTH'(req_wdata >> (g_idx * DATA_WIDTH));
  assign accept = state == IDLE && |req_valid;
  assign access = state == ACCESS;
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign rsp_valid = (state == RESP) ? NUM_REQ'(1) << gid : '0;
  assign mem_read_en = access && !lat.write && !lat_err;
  assign mem_write_en = access && lat.write && !lat_err && !rst;
  assign mem_addr = access ? lat.addr : '0;
  assign mem_write_data = access ? lat.wdata : '0;
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
  logic err_q;
  // Flag out-of-range addresses at accept and present the flag with the response
  always_ff @(posedge clk)
    if (rst) {lat_err, err_q} <= '0;
    else if (accept) {lat_err, err_q} <= {int'(sel_addr) >= MEM_DEPTH, 1'b0};
    else if (access) err_q <= lat_err;
  assign rsp_err = err_q;
`else
  assign lat_err = 1'b0;
  assign rsp_err = 1'b0;
`endif
  // Accept one request, perform one memory access, then hold the response until taken
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      gid <= '0;
      lat <= '0;
      rsp_rdata <= '0;
    end else case (state)
      IDLE: if (accept) begin
        lat <= '{write: req_write[g_idx], addr: sel_addr, wdata: sel_wdata};
        gid <= g_idx;
        rr_ptr <= IW'((int'(g_idx) + 1) % NUM_REQ);
        state <= ACCESS;
      end
      ACCESS: begin
        rsp_rdata <= (lat.write || lat_err) ? '0 : mem_read_data;
        state <= RESP;
      end
      RESP: if (rsp_ready[gid]) state <= IDLE;
      default: state <= IDLE;
    endcase
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory between NUM_REQ requesters (e.g. core load/store unit and a debug/DMA port).
- Round-robin arbitration and a valid/ready request handshake per requester.
- One fully sequenced memory access per grant, with a registered, backpressurable response.
- Sits between the requesters and the data memory's read_en/write_en/addr/write_data/read_data port.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 8, memory address width in bits
- DATA_WIDTH, 32, data word width in bits
- MEM_DEPTH, 256, number of valid words (used only by the bounds check)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accept; at most one bit high
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- rsp_valid  out  NUM_REQ  per-requester response valid
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_rdata  out  DATA_WIDTH  read data, shared by all requesters
- rsp_err  out  1  access error (bounds-check build only; else tied 0)
- mem_read_en  out  1  to memory read enable
- mem_write_en  out  1  to memory write enable
- mem_addr  out  ADDR_WIDTH  to memory address
- mem_write_data  out  DATA_WIDTH  to memory write data
- mem_read_data  in  DATA_WIDTH  from memory; combinational read

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0, and all of the following are 0: latched request, rsp_valid, rsp_rdata, rsp_err, req_ready, mem_*.
- Reset mid-transaction aborts with no response. mem_write_en is gated by !rst, so no write occurs in a reset cycle.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - The grant goes to the first i with req_valid[i], searching from rr_ptr upward, modulo NUM_REQ.
  - req_ready[g] is asserted combinationally in the same cycle; the handshake completes when valid&ready.
  - Latch write, addr, wdata and grant id g.
  - Set rr_ptr <= (g+1) mod NUM_REQ, then go to ACCESS.
  - If no requester is valid, stay in IDLE with req_ready=0.
- ACCESS (exactly 1 cycle):
  - Drive mem_addr and mem_write_data from the latched values.
  - mem_write_en = latched write; mem_read_en = !latched write.
  - A read captures mem_read_data into rsp_rdata at the clock edge. A write commits to memory at the same edge.
  - Go to RESP.
- RESP:
  - rsp_valid[g]=1; all other rsp_valid bits are 0.
  - rsp_rdata is held stable (0 for writes) until rsp_ready[g]=1, then go to IDLE.
  - req_ready=0 in RESP and ACCESS.
- Latency: accept at cycle T, memory access at T+1, rsp_valid at T+2. Peak throughput is one transaction per 3 cycles.
- mem_read_en and mem_write_en are never high together, and both are 0 outside ACCESS.
- Request inputs may change after the handshake; only latched values are used.
- Simultaneous requests: round-robin guarantees no starvation. With all NUM_REQ requesters continuously valid, each is granted once every NUM_REQ transactions.
- rsp_ready on a non-granted requester is ignored.

Optional Feature:
- Macro: DATA_MEM_ARB_BOUNDS_CHECK_EN.
- Defined: in IDLE, a latched addr >= MEM_DEPTH marks the transaction as an error.
  - In ACCESS both mem enables stay 0.
  - In RESP: rsp_err=1, rsp_rdata=0.
  - Handshake and timing are unchanged.
- Undefined: rsp_err is tied 0, and all addresses pass through to the memory.

Decomposition:
- Package data_mem_arb_pkg:
  - state enum arb_state_t {IDLE, ACCESS, RESP}
  - struct mem_req_t {write, addr, wdata}
  - parameter-default constants
- Sub-module rr_arbiter: combinational round-robin select.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index.
- The top level holds the FSM and registers.

Test Plan:
- Single write/read: req0 writes 0xDEADBEEF to addr 0x10 → mem_write_en=1 for exactly 1 cycle at T+1, rsp_valid[0] at T+2, rsp_rdata=0. req0 then reads 0x10 → rsp_rdata=0xDEADBEEF at T+2.
- Contention: req0 and req1 valid every cycle with rr_ptr=0 → grant order 0,1,0,1. Each req_ready pulse lasts 1 cycle. No simultaneous req_ready.
- Response backpressure: a read of addr 0x05 containing 0x1234, with rsp_ready[1] held low for 4 cycles → rsp_valid[1] and rsp_rdata=0x1234 stay stable for 4 cycles, req_ready stays 0, and IDLE is entered the cycle after rsp_ready.
- Reset during ACCESS: assert rst while a write of 0xA5A5A5A5 to 0x20 is in ACCESS → mem_write_en=0, and a later read of 0x20 returns the old value. After reset, all outputs are 0 and the next grant goes to requester 0.
- Bounds check (DATA_MEM_ARB_BOUNDS_CHECK_EN, MEM_DEPTH=128): write to addr 0xF0 → no mem enable asserted, rsp_err=1 at T+2. Without the macro, rsp_err stays 0.
